// File: rtl/mem_responder.sv
// Memory-side responder for the single-word req/done protocol: one access at a
// time, fixed programmable latency, word-addressed array with a host backdoor.
module mem_responder #(
  parameter int          DW        = 32,
  parameter int          DEPTH     = 64,
  parameter int          AW        = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [31:0]   mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_done,
  output logic          mem_err,
  output logic          busy,
  input  logic          bd_we,
  input  logic [AW-1:0] bd_addr,
  input  logic [DW-1:0] bd_wdata,
  output logic [DW-1:0] bd_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [DW-1:0] ILLEGAL_RDATA = DW'(32'hDEAD_BEEF);

  state_t          state_r, state_nx_s;
  logic [3:0]      cnt_r, cnt_nx_s;
  logic            we_r;
  logic [31:0]     addr_r;
  logic [DW-1:0]   wdata_r;
  logic [DW-1:0]   mem_r [DEPTH];
  logic            legal_s;
  logic [AW-1:0]   idx_s;
  logic            done_edge_s;
  logic            proto_we_s;

  // Underflow of the 32-bit subtraction is caught by the explicit >= test.
  function automatic logic addr_legal(input logic [31:0] a);
    return (a >= BASE_ADDR) && (a[1:0] == 2'b00) &&
           (((a - BASE_ADDR) >> 2) < 32'(DEPTH));
  endfunction

  function automatic logic [AW-1:0] addr_index(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  assign legal_s     = addr_legal(addr_r);
  assign idx_s       = addr_index(addr_r);
  assign done_edge_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);
  assign proto_we_s  = done_edge_s && we_r && legal_s && !rst;

  // Next-state and latency counter logic.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_req) begin
          state_nx_s = ST_WAIT;
          cnt_nx_s   = 4'(LATENCY - 1);
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nx_s = ST_DONE;
        end else begin
          cnt_nx_s = cnt_r - 4'd1;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

  // State, request capture and registered protocol outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      we_r      <= 1'b0;
      addr_r    <= 32'd0;
      wdata_r   <= '0;
      mem_done  <= 1'b0;
      mem_err   <= 1'b0;
      busy      <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state_r  <= state_nx_s;
      cnt_r    <= cnt_nx_s;
      busy     <= (state_nx_s != ST_IDLE);
      mem_done <= done_edge_s;
      mem_err  <= done_edge_s && !legal_s;
      if ((state_r == ST_IDLE) && mem_req) begin
        we_r    <= mem_we;
        addr_r  <= mem_addr;
        wdata_r <= mem_wdata;
      end
      if (done_edge_s && !we_r) begin
        mem_rdata <= legal_s ? mem_r[idx_s] : ILLEGAL_RDATA;
      end
    end
  end

  // Storage array; the protocol write is last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem_r[bd_addr] <= bd_wdata;
    end
    if (proto_we_s) begin
      mem_r[idx_s] <= wdata_r;
    end
  end

  // Backdoor read port, returns the pre-write value on a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      bd_rdata <= '0;
    end else begin
      bd_rdata <= mem_r[bd_addr];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder: two instances (LATENCY 2 at
// base 0, LATENCY 1 at base 0x1000) against a word-array reference model.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst, req, we, bd_we, done, err, busy;
  logic [1:0][31:0]  addr, wdata, rdata, bd_wdata, bd_rdata;
  logic [1:0][5:0]   bd_addr;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model [2][64];
  logic [31:0] last_rd [2];
  logic        model_err [2];

  mem_responder #(.DW(32), .DEPTH(64), .AW(6), .BASE_ADDR(32'h0000_0000), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst[0]), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_done(done[0]), .mem_err(err[0]),
    .busy(busy[0]), .bd_we(bd_we[0]), .bd_addr(bd_addr[0]), .bd_wdata(bd_wdata[0]),
    .bd_rdata(bd_rdata[0]));

  mem_responder #(.DW(32), .DEPTH(64), .AW(6), .BASE_ADDR(32'h0000_1000), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst[1]), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_done(done[1]), .mem_err(err[1]),
    .busy(busy[1]), .bd_we(bd_we[1]), .bd_addr(bd_addr[1]), .bd_wdata(bd_wdata[1]),
    .bd_rdata(bd_rdata[1]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic longint base_of(input int d);
    return (d == 0) ? 64'd0 : 64'h1000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: legality and indexing from plain integer arithmetic on the byte address.
  function automatic void model_access(input int d, input bit w, input logic [31:0] a,
                                       input logic [31:0] wd);
    longint off;
    int     idx;
    bit     ok;
    off = longint'({32'd0, a}) - base_of(d);
    ok  = (off >= 0) && (off % 4 == 0) && (off < 4 * 64);
    idx = ok ? int'(off / 4) : 0;
    model_err[d] = !ok;
    if (!w) last_rd[d] = ok ? model[d][idx] : 32'hDEAD_BEEF;
    else if (ok) model[d][idx] = wd;
  endfunction

  task automatic bd_write(input int d, input int idx, input logic [31:0] val);
    @(negedge clk);
    bd_we[d] = 1'b1; bd_addr[d] = 6'(idx); bd_wdata[d] = val;
    @(negedge clk);
    bd_we[d] = 1'b0;
    model[d][idx] = val;
  endtask

  task automatic bd_check(input int d, input int idx, input string tag);
    @(negedge clk);
    bd_addr[d] = 6'(idx);
    @(negedge clk);
    chk(tag, bd_rdata[d], model[d][idx]);
  endtask

  // One protocol access; optional backdoor write placed before the edge ending cycle bd_at.
  task automatic do_op(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input int bd_at, input int bd_idx, input logic [31:0] bd_val);
    int n;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n++;
      req[d]      = 1'b0;
      bd_we[d]    = (n == bd_at);
      bd_addr[d]  = 6'(bd_idx);
      bd_wdata[d] = bd_val;
      if (done[d] !== 1'b1) chk("busy_wait", {31'd0, busy[d]}, 32'd1);
      if (done[d] === 1'b1) break;
    end
    bd_we[d] = 1'b0;
    chk("done_latency", n, lat_of(d) + 1);
    if (!w) model_access(d, w, a, wd);
    if (bd_at > 0) model[d][bd_idx] = bd_val;
    if (w) model_access(d, w, a, wd);
    chk("busy_at_done", {31'd0, busy[d]}, 32'd1);
    chk("err", {31'd0, err[d]}, {31'd0, model_err[d]});
    chk("rdata", rdata[d], last_rd[d]);
    @(negedge clk);
    chk("done_pulse_1cyc", {31'd0, done[d]}, 32'd0);
    chk("busy_after", {31'd0, busy[d]}, 32'd0);
  endtask

  initial begin
    int          k, since, r, idx;
    logic [31:0] a, cur_a;
    rst = 2'b11; req = '0; we = '0; bd_we = '0; addr = '0; wdata = '0;
    bd_wdata = '0; bd_addr = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_done", {31'd0, done[d]}, 32'd0);
      chk("rst_err", {31'd0, err[d]}, 32'd0);
      chk("rst_busy", {31'd0, busy[d]}, 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
      chk("rst_bd_rdata", bd_rdata[d], 32'd0);
    end
    // Preload both arrays through the backdoor while still in reset.
    for (int i = 0; i < 64; i++) begin
      bd_we = 2'b11;
      for (int d = 0; d < 2; d++) begin
        bd_addr[d]  = 6'(i);
        bd_wdata[d] = $urandom;
        model[d][i] = bd_wdata[d];
      end
      @(negedge clk);
    end
    bd_we = 2'b00;
    @(negedge clk);
    chk("rst_bd_rdata_held", bd_rdata[0], 32'd0);
    rst = 2'b00;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;

    // Basic read with latency 2.
    bd_write(0, 5, 32'h0000_0007);
    do_op(0, 1'b0, 32'h14, 32'd0, -1, 0, 32'd0);
    chk("read5_value", rdata[0], 32'd7);

    // Write then read back through both ports.
    do_op(0, 1'b1, 32'h08, 32'h1234, -1, 0, 32'd0);
    do_op(0, 1'b0, 32'h08, 32'd0, -1, 0, 32'd0);
    chk("raw_value", rdata[0], 32'h1234);
    bd_check(0, 2, "bd_after_write");

    // Illegal accesses.
    do_op(0, 1'b0, 32'h0A, 32'd0, -1, 0, 32'd0);
    chk("misaligned_rd", rdata[0], 32'hDEAD_BEEF);
    do_op(0, 1'b1, 32'h0A, 32'h5555, -1, 0, 32'd0);
    bd_check(0, 2, "misaligned_wr_nochange");
    do_op(0, 1'b0, 32'h0000_0100, 32'd0, -1, 0, 32'd0);
    do_op(0, 1'b1, 32'h0000_0100, 32'h6666, -1, 0, 32'd0);
    do_op(1, 1'b0, 32'h0000_0FFC, 32'd0, -1, 0, 32'd0);
    chk("below_base_rd", rdata[1], 32'hDEAD_BEEF);
    do_op(1, 1'b0, 32'h0000_1004, 32'd0, -1, 0, 32'd0);

    // Protocol write and backdoor write to the same index on the same edge.
    do_op(0, 1'b1, 32'h0C, 32'h0000_AAAA, 2, 3, 32'h0000_BBBB);
    bd_check(0, 3, "collision_bd");
    chk("collision_value", bd_rdata[0], 32'h0000_AAAA);

    // Request held high on the latency-1 instance: one done every 3 cycles.
    cur_a = 32'h1000 + 32'(4 * $urandom_range(0, 70));
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = cur_a;
    since = 0; k = 0;
    for (int c = 0; c < 150 && k < 18; c++) begin
      @(negedge clk);
      since++;
      if (done[1] === 1'b1) begin
        k++;
        chk("held_gap", since, (k == 1) ? 32'd2 : 32'd3);
        since = 0;
        model_access(1, 1'b0, cur_a, 32'd0);
        chk("held_err", {31'd0, err[1]}, {31'd0, model_err[1]});
        chk("held_rdata", rdata[1], last_rd[1]);
        cur_a = 32'h1000 + 32'(4 * $urandom_range(0, 70));
        addr[1] = cur_a;
        if (k == 18) req[1] = 1'b0;
      end
    end
    req[1] = 1'b0;
    chk("held_count", k, 32'd18);
    @(negedge clk);
    chk("held_busy_end", {31'd0, busy[1]}, 32'd0);

    // Reset on the edge that would enter DONE for a write to index 4.
    bd_write(0, 4, 32'h55);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h99;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    last_rd[0] = 32'd0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      if (done[0] === 1'b1) k++;
      @(negedge clk);
    end
    chk("rst_mid_no_done", k, 32'd0);
    chk("rst_mid_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_mid_rdata", rdata[0], 32'd0);
    bd_check(0, 4, "rst_mid_bd");
    chk("rst_mid_value", bd_rdata[0], 32'h55);
    do_op(0, 1'b0, 32'h10, 32'd0, -1, 0, 32'd0);

    // Randomized traffic mixing legal, misaligned, out-of-range and below-base addresses.
    for (int t = 0; t < 60; t++) begin
      int d;
      d   = int'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, 63));
      if (r <= 6)      a = 32'(base_of(d)) + 32'(4 * idx);
      else if (r == 7) a = 32'(base_of(d)) + 32'(4 * idx) + 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'(base_of(d)) + 32'd256 + 32'(4 * idx);
      else             a = 32'(base_of(d)) - 32'(4 * (idx + 1));
      do_op(d, 1'($urandom_range(0, 1)), a, $urandom, -1, 0, 32'd0);
    end
    for (int t = 0; t < 8; t++) begin
      bd_check(t % 2, int'($urandom_range(0, 63)), "final_bd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the single-word request/done memory protocol used by the matrix-multiply top-level.
- Accepts one read or write request at a time, waits a programmable latency, then completes with a one-cycle done pulse. Read data is valid on that pulse.
- Backs a word-addressed storage array. A backdoor port lets the host or bench preload operand matrices and read back results.
- Sits between the multiply engine's memory port and the system (or bench) memory image.

Parameters:
- DW, 32, data word width.
- DEPTH, 64, number of words in the array; power of two, ≥ 2.
- AW, 6, backdoor index width; equals log2(DEPTH).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; 4-byte aligned.
- LATENCY, 2, cycles from request acceptance to done; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- mem_req  in  1  request strobe (level); sampled only in IDLE.
- mem_we  in  1  1 = write, 0 = read; sampled with mem_req.
- mem_addr  in  32  byte address; sampled with mem_req.
- mem_wdata  in  DW  write data; sampled with mem_req.
- mem_rdata  out  DW  read data; valid in the mem_done cycle, held until the next read completes.
- mem_done  out  1  one-cycle completion pulse.
- mem_err  out  1  set with mem_done when the access was illegal.
- busy  out  1  high from acceptance through the done cycle.
- bd_we  in  1  backdoor write enable.
- bd_addr  in  AW  backdoor word index.
- bd_wdata  in  DW  backdoor write data.
- bd_rdata  out  DW  registered backdoor read of array[bd_addr]; 1-cycle latency.

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: state = IDLE, mem_done = 0, mem_err = 0, busy = 0, mem_rdata = 0, bd_rdata = 0, latency counter = 0.
- Array contents are not cleared by reset and are undefined after power-up.
- States: IDLE, WAIT, DONE.
- IDLE:
  - When mem_req = 1 at a clock edge, latch mem_we, mem_addr and mem_wdata.
  - Load the counter with LATENCY-1 and go to WAIT; busy = 1 from that edge.
  - mem_req = 0 stays in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter = 0, go to DONE on the next edge.
  - mem_req is ignored in WAIT.
- DONE:
  - Lasts exactly one cycle with mem_done = 1, then returns to IDLE.
  - mem_req high during the DONE cycle is ignored. The earliest next acceptance is the first IDLE cycle, so back-to-back requests cost LATENCY+2 cycles each.
- Latency: if acceptance happens at edge t, mem_done is high in the cycle after edge t+LATENCY. For LATENCY = 1, WAIT lasts one cycle.
- Address legality:
  - Index = (addr − BASE_ADDR) >> 2.
  - The access is legal iff addr ≥ BASE_ADDR, addr[1:0] = 0 and index < DEPTH.
  - Subtraction is 32-bit unsigned; an underflow counts as illegal.
- Legal read: mem_rdata = array[index], registered on the edge entering DONE; mem_err = 0.
- Legal write: array[index] = latched wdata on the edge entering DONE; mem_rdata unchanged; mem_err = 0.
- Illegal access: no array write; mem_err = 1 with mem_done. An illegal read returns mem_rdata = 32'hDEAD_BEEF.
- Read-after-write: a read accepted after a write's done sees the new data.
- Backdoor:
  - bd_we writes array[bd_addr] at the edge; allowed in any state, including during reset.
  - If a backdoor write and a protocol write hit the same index on the same edge, the protocol write wins.
  - bd_rdata returns the pre-write value when reading and writing the same index on the same edge.
- Reset mid-operation: an in-flight request is dropped; no done is issued and no array write occurs, even if reset coincides with the DONE-entry edge.

Test Plan:
- LATENCY = 2: backdoor-load array[5] = 32'h0000_0007; read request with mem_addr = 0x14 → mem_done high exactly 3 cycles after the acceptance edge, mem_rdata = 7, mem_err = 0, busy high for 3 cycles.
- Write mem_addr = 0x08, wdata = 32'h1234 → done with mem_err = 0; then read 0x08 → 32'h1234; bd_rdata at bd_addr = 2 → 32'h1234.
- Misaligned 0x0A, out-of-range 0x100 (DEPTH = 64), and BASE_ADDR = 0x1000 with addr 0x0FFC → each gives mem_done with mem_err = 1; illegal reads return 32'hDEAD_BEEF; array unchanged.
- mem_req held high continuously for 18 accesses with LATENCY = 1 → one done every 3 cycles; no request is accepted during WAIT or DONE.
- Same-edge protocol write 0xAAAA and backdoor write 0xBBBB to index 3 → array[3] = 0xAAAA.
- rst asserted in WAIT during a write to index 4 (previously 0x55) → mem_done never pulses, array[4] = 0x55, busy = 0, state IDLE; the next request completes normally.
